// File: rtl/base_n_digit_counter.sv
// Single-digit modulo-BASE counter with terminal-count flag for cascading.
// Optional synchronous clear input enabled by defining BASE_N_COUNTER_CLR_EN.
module base_n_digit_counter #(
  parameter  int unsigned BASE  = 10,
  localparam int unsigned WIDTH = ($clog2(BASE) < 1) ? 1 : $clog2(BASE)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
`ifdef BASE_N_COUNTER_CLR_EN
  input  logic             clr,
`endif
  output logic [WIDTH-1:0] count_out,
  output logic             ena_next
);

  if (BASE < 2) begin : g_bad_base
    $error("base_n_digit_counter: BASE must be >= 2");
  end

  localparam logic [WIDTH-1:0] LAST = WIDTH'(BASE - 1);

  logic [WIDTH-1:0] r_count;
  logic             w_at_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end
`ifdef BASE_N_COUNTER_CLR_EN
    else if (clr) begin
      r_count <= '0;
    end
`endif
    else if (ena) begin
      // >= rather than == so an unreachable code above BASE-1 recovers to 0
      if (r_count >= LAST) r_count <= '0;
      else                 r_count <= r_count + WIDTH'(1);
    end
  end

  assign w_at_last = (r_count == LAST);
  assign count_out = r_count;
  assign ena_next  = w_at_last;

endmodule

// File: tb/tb_base_n_digit_counter.sv
// Table-driven scoreboard bench: BASE=2, BASE=10 and a four-digit decimal chain.
module tb_base_n_digit_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst2 = 1'b1, ena2 = 1'b0;
  logic rst10 = 1'b1, ena10 = 1'b0;
  logic rstc = 1'b1, enac = 1'b0;
`ifdef BASE_N_COUNTER_CLR_EN
  logic clr10 = 1'b0;
`endif

  logic       c2, n2;
  logic [3:0] c10;
  logic       n10;
  logic [3:0] d0, d1, d2, d3;
  logic       n0, n1, n2c, n3;
  logic       e1, e2, e3;

  assign e1 = enac & n0;
  assign e2 = e1 & n1;
  assign e3 = e2 & n2c;

  base_n_digit_counter #(.BASE(2)) u_b2 (
    .clk(clk), .rst(rst2), .ena(ena2),
`ifdef BASE_N_COUNTER_CLR_EN
    .clr(1'b0),
`endif
    .count_out(c2), .ena_next(n2));

  base_n_digit_counter #(.BASE(10)) u_b10 (
    .clk(clk), .rst(rst10), .ena(ena10),
`ifdef BASE_N_COUNTER_CLR_EN
    .clr(clr10),
`endif
    .count_out(c10), .ena_next(n10));

  base_n_digit_counter #(.BASE(10)) u_d0 (
    .clk(clk), .rst(rstc), .ena(enac),
`ifdef BASE_N_COUNTER_CLR_EN
    .clr(1'b0),
`endif
    .count_out(d0), .ena_next(n0));

  base_n_digit_counter #(.BASE(10)) u_d1 (
    .clk(clk), .rst(rstc), .ena(e1),
`ifdef BASE_N_COUNTER_CLR_EN
    .clr(1'b0),
`endif
    .count_out(d1), .ena_next(n1));

  base_n_digit_counter #(.BASE(10)) u_d2 (
    .clk(clk), .rst(rstc), .ena(e2),
`ifdef BASE_N_COUNTER_CLR_EN
    .clr(1'b0),
`endif
    .count_out(d2), .ena_next(n2c));

  base_n_digit_counter #(.BASE(10)) u_d3 (
    .clk(clk), .rst(rstc), .ena(e3),
`ifdef BASE_N_COUNTER_CLR_EN
    .clr(1'b0),
`endif
    .count_out(d3), .ena_next(n3));

  // sel: 0 = BASE=2 instance, 1 = BASE=10 instance, 2 = four-digit chain
  typedef struct {
    int unsigned sel;
    logic        rst;
    logic        ena;
    logic        clr;
    int unsigned val;
    logic [3:0]  nxt;
    string       name;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic void add(input int unsigned sel, input logic r, input logic e,
                              input logic c, input int unsigned v, input logic [3:0] n,
                              input string nm);
    vec_t t;
    t.sel = sel; t.rst = r; t.ena = e; t.clr = c; t.val = v; t.nxt = n; t.name = nm;
    vecs.push_back(t);
  endfunction

  function automatic logic [3:0] chain_flags(input int unsigned v);
    logic [3:0]  f;
    int unsigned x;
    x = v;
    for (int i = 0; i < 4; i++) begin
      f[i] = ((x % 10) == 9);
      x = x / 10;
    end
    return f;
  endfunction

  task automatic apply(input vec_t v);
    vec_t        e;
    int unsigned av;
    logic [3:0]  an;
    @(negedge clk);
    case (v.sel)
      0: begin rst2 = v.rst; ena2 = v.ena; end
      1: begin
        rst10 = v.rst; ena10 = v.ena;
`ifdef BASE_N_COUNTER_CLR_EN
        clr10 = v.clr;
`endif
      end
      default: begin rstc = v.rst; enac = v.ena; end
    endcase
    sb.push_back(v);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    case (e.sel)
      0: begin av = 32'(c2); an = {3'b000, n2}; end
      1: begin av = 32'(c10); an = {3'b000, n10}; end
      default: begin
        av = 32'(d0) + 32'd10 * 32'(d1) + 32'd100 * 32'(d2) + 32'd1000 * 32'(d3);
        an = {n3, n2c, n1, n0};
      end
    endcase
    n_vec++;
    if (av !== e.val || an !== e.nxt) begin
      n_err++;
      $display("FAIL %s: count=%0d ena_next=%b, expected count=%0d ena_next=%b",
               e.name, av, an, e.val, e.nxt);
    end
  endtask

  initial begin
    // BASE=2: reset held with ena high, then free-running toggle
    for (int i = 0; i < 10; i++) add(0, 1'b1, 1'b1, 1'b0, 0, 4'd0, "b2_reset");
    for (int i = 1; i <= 8; i++) add(0, 1'b0, 1'b1, 1'b0, i % 2, 4'(i % 2), "b2_toggle");

    // BASE=10: reset, count through a wrap up to 5, then hold
    for (int i = 0; i < 10; i++) add(1, 1'b1, 1'b1, 1'b0, 0, 4'd0, "b10_reset");
    for (int i = 1; i <= 15; i++)
      add(1, 1'b0, 1'b1, 1'b0, i % 10, 4'((i % 10) == 9), "b10_count");
    for (int i = 0; i < 3; i++) add(1, 1'b0, 1'b0, 1'b0, 5, 4'd0, "b10_hold5");
    for (int i = 6; i <= 9; i++) add(1, 1'b0, 1'b1, 1'b0, i, 4'(i == 9), "b10_to9");
    // terminal flag stays up at 9 even with ena low
    for (int i = 0; i < 2; i++) add(1, 1'b0, 1'b0, 1'b0, 9, 4'd1, "b10_hold9");
    add(1, 1'b1, 1'b1, 1'b0, 0, 4'd0, "b10_rst_mid");
    add(1, 1'b0, 1'b1, 1'b0, 1, 4'd0, "b10_resume");
`ifdef BASE_N_COUNTER_CLR_EN
    for (int i = 2; i <= 7; i++) add(1, 1'b0, 1'b1, 1'b0, i, 4'd0, "b10_to7");
    add(1, 1'b0, 1'b1, 1'b1, 0, 4'd0, "b10_clr_at7");
    add(1, 1'b0, 1'b1, 1'b0, 1, 4'd0, "b10_after_clr");
    add(1, 1'b0, 1'b1, 1'b0, 2, 4'd0, "b10_count2");
    add(1, 1'b1, 1'b1, 1'b1, 0, 4'd0, "b10_rst_clr");
    add(1, 1'b0, 1'b0, 1'b1, 0, 4'd0, "b10_clr_noena");
`endif

    // Four-digit chain: full 0..9999 sweep with wrap, then reset at 1234
    for (int i = 0; i < 3; i++) add(2, 1'b1, 1'b1, 1'b0, 0, 4'd0, "chain_reset");
    for (int k = 1; k <= 10000; k++)
      add(2, 1'b0, 1'b1, 1'b0, k % 10000, chain_flags(k % 10000), "chain_count");
    for (int k = 1; k <= 1234; k++)
      add(2, 1'b0, 1'b1, 1'b0, k, chain_flags(k), "chain_recount");
    add(2, 1'b1, 1'b1, 1'b0, 0, 4'd0, "chain_rst_1234");
    add(2, 1'b0, 1'b1, 1'b0, 1, 4'd0, "chain_resume");
    add(2, 1'b0, 1'b1, 1'b0, 2, 4'd0, "chain_resume2");

    foreach (vecs[i]) apply(vecs[i]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
